issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Issue-control scoreboard sitting beside the decode stage. It gates each decoded instruction into the ALU path or the 5-stage multiply path.
- Tracks in-flight register writes per destination register and reserves the single register-file write-back slot.
- Stalls decode on three conditions: a RAW operand not yet reachable by a bypass, a write-back port collision between the ALU/load and multiply paths, or a WAW reorder.
- Also provides a stall-cycle performance counter.

Parameters:
- NUM_REGS, 32, number of architectural integer registers.
- REGISTER_WIDTH, 5, register index width.
- ALU_READY, 1, cycles from issue until an ALU/CSR/LUI/JAL result is bypassable.
- LOAD_READY, 2, cycles from issue until load data is bypassable (mem stage).
- MUL_READY, 5, cycles from issue until multiply result is bypassable (ex5).
- ALU_WB, 3, cycles from issue to register-file write for the ALU and load class.
- MUL_WB, 6, cycles from issue to register-file write for multiply.
- WB_SLOTS, 8, write-back reservation window depth; must be greater than MUL_WB.
- CNT_WIDTH, 3, per-register countdown width; 2^CNT_WIDTH must be greater than MUL_READY.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- dec_valid_i  in  1  decode holds a valid instruction.
- flush_i  in  1  jump or taken branch; kills the instruction in decode.
- rs1_i  in  REGISTER_WIDTH  source 1 index.
- rs2_i  in  REGISTER_WIDTH  source 2 index.
- rs1_needed_i  in  1  source 1 is read.
- rs2_needed_i  in  1  source 2 is read.
- rd_i  in  REGISTER_WIDTH  destination index.
- is_wb_i  in  1  instruction writes rd.
- is_load_i  in  1  instruction is a load.
- is_mul_i  in  1  instruction is a multiply.
- stall_o  out  1  hold fetch and decode this cycle.
- stall_raw_o  out  1  stall cause: RAW.
- stall_struct_o  out  1  stall cause: write-back slot conflict.
- stall_waw_o  out  1  stall cause: WAW.
- issue_o  out  1  instruction leaves decode this cycle.
- pending_o  out  NUM_REGS  bit r set when cnt[r] is nonzero.
- idle_o  out  1  no pending registers and no reserved write-back slots.
- stall_cycles_o  out  32  count of cycles with stall_o high.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high (rst_i).
- Reset state: all cnt[r] = 0, wb_busy = 0, stall_cycles_o = 0. Consequently stall_o = 0, pending_o = 0, idle_o = 1.
- Latency class selection: MUL if is_mul_i, else LOAD if is_load_i, else ALU.
  - L = MUL_READY, LOAD_READY or ALU_READY respectively.
  - W = MUL_WB for MUL, ALU_WB for LOAD and ALU.
- Write-valid: wv = is_wb_i and rd_i != 0.
- RAW stall: (rs1_needed_i and rs1_i != 0 and cnt[rs1_i] != 0) or the same condition on rs2.
- Structural stall: wv and wb_busy[W]. wb_busy[k] set means the write-back slot k cycles ahead is taken.
- WAW stall: wv and cnt[rd_i] >= L, i.e. the older writer becomes ready no earlier than the new one would.
- Stall outputs:
  - The cause outputs are combinational and gated by dec_valid_i and not flush_i.
  - stall_o is the OR of the three causes.
- Issue: issue_o = dec_valid_i and not flush_i and not stall_o. All outputs are combinational from the current state and inputs.
- Countdowns, updated each clock:
  - every nonzero cnt[r] decrements by 1;
  - if issue_o and wv, cnt[rd_i] is loaded with L-1. The load overrides the decrement for that register.
- Write-back reservation, updated each clock: wb_busy <= (wb_busy >> 1) OR (issue_o and wv ? one-hot bit W-1 : 0).
- Non-writing instructions (store, branch, rd = x0) issue without touching cnt or wb_busy.
- Flush: blocks only the decode instruction. Instructions already in flight keep their cnt and wb_busy entries.
- Stall counter: stall_cycles_o increments when stall_o is high and wraps at 2^32.
- Reset mid-operation: all in-flight state is cleared on the next edge, with no ordering guarantee for the dropped instructions.
- Same-cycle read and set: a source compares against the pre-update cnt. Back-to-back dependent ALU instructions therefore never stall, because cnt = ALU_READY-1 = 0.

Test Plan:
- Reset, then an ALU write to x5 followed by an ALU read of x5 -> both issue_o = 1, no stall, pending_o = 0 after each edge.
- Load to x6 followed by an add reading x6 -> one stall_raw_o cycle, then issue; stall_cycles_o = 1.
- Mul to x7 followed by an add reading x7 -> exactly 4 stall cycles, issue on the 5th; pending_o[7] high for 4 cycles.
- Mul to x8 at cycle t, unrelated ALU to x9 at t+3 -> stall_struct_o at t+3 (both write back at t+6); ALU issues at t+4.
- Mul to x10 followed by an ALU write to x10 with no read -> stall_waw_o until cnt[10] < 1, then issue; rd = x0 writes never stall and never set pending.
- flush_i asserted with a dependent instruction in decode -> stall_o = 0, issue_o = 0, state unchanged; rst_i asserted with x7 pending -> pending_o = 0 and idle_o = 1 after the edge.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// issue_scoreboard_if: decode-side issue request and scoreboard stall/status signals
interface issue_scoreboard_if #(
  parameter int NUM_REGS       = 32,
  parameter int REGISTER_WIDTH = 5
);
  logic                      dec_valid;
  logic                      flush;
  logic [REGISTER_WIDTH-1:0] rs1;
  logic [REGISTER_WIDTH-1:0] rs2;
  logic                      rs1_needed;
  logic                      rs2_needed;
  logic [REGISTER_WIDTH-1:0] rd;
  logic                      is_wb;
  logic                      is_load;
  logic                      is_mul;
  logic                      stall;
  logic                      stall_raw;
  logic                      stall_struct;
  logic                      stall_waw;
  logic                      issue;
  logic [NUM_REGS-1:0]       pending;
  logic                      idle;
  logic [31:0]               stall_cycles;
  modport master (
    output dec_valid, flush, rs1, rs2, rs1_needed, rs2_needed, rd, is_wb, is_load, is_mul,
    input  stall, stall_raw, stall_struct, stall_waw, issue, pending, idle, stall_cycles
  );
  modport slave (
    input  dec_valid, flush, rs1, rs2, rs1_needed, rs2_needed, rd, is_wb, is_load, is_mul,
    output stall, stall_raw, stall_struct, stall_waw, issue, pending, idle, stall_cycles
  );
endinterface

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: RAW/WAW/write-back-slot hazard gating of decoded instructions
module issue_scoreboard #(
  parameter int NUM_REGS       = 32,
  parameter int REGISTER_WIDTH = 5,
  parameter int ALU_READY      = 1,
  parameter int LOAD_READY     = 2,
  parameter int MUL_READY      = 5,
  parameter int ALU_WB         = 3,
  parameter int MUL_WB         = 6,
  parameter int WB_SLOTS       = 8,
  parameter int CNT_WIDTH      = 3
) (
  input logic clk_i,
  input logic rst_i,
  issue_scoreboard_if.slave sb
);
  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
  logic [WB_SLOTS-1:0]  wb_busy;
  logic [WB_SLOTS-1:0]  wset;
  logic [CNT_WIDTH-1:0] lat;
  logic [31:0]          stall_cnt;
  logic                 wv;
  logic                 go;
  logic                 raw;
  logic                 strc;
  logic                 waw;
  always_comb begin
    lat = sb.is_mul ? CNT_WIDTH'(MUL_READY) : sb.is_load ? CNT_WIDTH'(LOAD_READY) : CNT_WIDTH'(ALU_READY);
    wset = sb.is_mul ? WB_SLOTS'(1) << (MUL_WB - 1) : WB_SLOTS'(1) << (ALU_WB - 1);
    wv = sb.is_wb && sb.rd != '0;
    go = sb.dec_valid && !sb.flush;
    raw = (sb.rs1_needed && sb.rs1 != '0 && cnt[sb.rs1] != '0) ||
          (sb.rs2_needed && sb.rs2 != '0 && cnt[sb.rs2] != '0);
    // slot W ahead now is the slot that bit W-1 of the shifted vector will occupy
    strc = wv && |((wb_busy >> 1) & wset);
    waw = wv && cnt[sb.rd] >= lat;
    sb.stall_raw = go && raw;
    sb.stall_struct = go && strc;
    sb.stall_waw = go && waw;
    sb.stall = sb.stall_raw || sb.stall_struct || sb.stall_waw;
    sb.issue = go && !sb.stall;
    sb.pending = '0;
    for (int r = 0; r < NUM_REGS; r++) sb.pending[r] = cnt[r] != '0;
    sb.idle = sb.pending == '0 && wb_busy == '0;
    sb.stall_cycles = stall_cnt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_busy <= '0;
      stall_cnt <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      wb_busy <= (wb_busy >> 1) | (sb.issue && wv ? wset : '0);
      if (sb.stall) stall_cnt <= stall_cnt + 32'd1;
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= (sb.issue && wv && sb.rd == REGISTER_WIDTH'(r)) ? lat - CNT_WIDTH'(1)
                : cnt[r] - CNT_WIDTH'(cnt[r] != '0);
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed hazard scenarios with hand-computed expectations
module tb_issue_scoreboard;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  issue_scoreboard_if bus ();
  issue_scoreboard dut (.clk_i(clk), .rst_i(rst), .sb(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic instr(input logic v, input logic fl, input logic [4:0] r1, input logic n1,
                       input logic [4:0] r2, input logic n2, input logic [4:0] rd,
                       input logic wb, input logic ld, input logic mul);
    bus.dec_valid = v; bus.flush = fl;
    bus.rs1 = r1; bus.rs1_needed = n1; bus.rs2 = r2; bus.rs2_needed = n2;
    bus.rd = rd; bus.is_wb = wb; bus.is_load = ld; bus.is_mul = mul;
    #1;
  endtask
  task automatic nop();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic next();
    @(negedge clk);
  endtask
  initial begin
    nop();
    repeat (2) next();
    rst = 0;
    #1;
    check("rst_stall", bus.stall, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_idle", bus.idle, 1);
    check("rst_cycles", bus.stall_cycles, 0);
    // back-to-back ALU dependency
    next(); instr(1, 0, 0, 0, 0, 0, 5, 1, 0, 0);
    check("alu_wr_issue", bus.issue, 1);
    next(); check("alu_wr_pend", bus.pending, 0);
    instr(1, 0, 5, 1, 5, 1, 11, 1, 0, 0);
    check("alu_rd_issue", bus.issue, 1);
    check("alu_rd_stall", bus.stall, 0);
    next(); check("alu_rd_pend", bus.pending, 0);
    // load-use: one RAW bubble
    instr(1, 0, 0, 0, 0, 0, 6, 1, 1, 0);
    check("ld_issue", bus.issue, 1);
    next(); check("ld_pend6", bus.pending[6], 1);
    instr(1, 0, 6, 1, 0, 0, 12, 1, 0, 0);
    check("ld_raw", bus.stall_raw, 1);
    check("ld_raw_noissue", bus.issue, 0);
    next(); #1;
    check("ld_cycles", bus.stall_cycles, 1);
    check("ld_use_issue", bus.issue, 1);
    next();
    // multiply-use: four RAW bubbles
    instr(1, 0, 0, 0, 0, 0, 7, 1, 0, 1);
    check("mul_issue", bus.issue, 1);
    next(); instr(1, 0, 0, 0, 7, 1, 13, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mul_raw%0d", i), bus.stall_raw, 1);
      check($sformatf("mul_pend%0d", i), bus.pending[7], 1);
      next(); #1;
    end
    check("mul_use_issue", bus.issue, 1);
    check("mul_pend_clr", bus.pending[7], 0);
    check("mul_cycles", bus.stall_cycles, 5);
    next();
    // write-back slot collision between multiply and ALU
    instr(1, 0, 0, 0, 0, 0, 8, 1, 0, 1);
    check("wb_mul_issue", bus.issue, 1);
    next(); nop(); next(); nop(); next();
    instr(1, 0, 0, 0, 0, 0, 9, 1, 0, 0);
    check("wb_struct", bus.stall_struct, 1);
    check("wb_struct_noissue", bus.issue, 0);
    check("wb_busy_idle", bus.idle, 0);
    next(); #1;
    check("wb_struct_clr", bus.stall_struct, 0);
    check("wb_alu_issue", bus.issue, 1);
    check("wb_cycles", bus.stall_cycles, 6);
    next();
    // WAW against an older multiply
    instr(1, 0, 0, 0, 0, 0, 10, 1, 0, 1);
    check("waw_mul_issue", bus.issue, 1);
    next(); instr(1, 0, 0, 0, 0, 0, 10, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("waw%0d", i), bus.stall_waw, 1);
      check($sformatf("waw_noissue%0d", i), bus.issue, 0);
      next(); #1;
    end
    check("waw_issue", bus.issue, 1);
    check("waw_cycles", bus.stall_cycles, 10);
    next(); check("waw_pend", bus.pending, 0);
    instr(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("x0_stall", bus.stall, 0);
    check("x0_issue", bus.issue, 1);
    next(); check("x0_pend", bus.pending, 0);
    // flush with a dependent instruction in decode, then reset while pending
    instr(1, 0, 0, 0, 0, 0, 7, 1, 0, 1);
    next(); instr(1, 1, 7, 1, 0, 0, 14, 1, 0, 0);
    check("fl_stall", bus.stall, 0);
    check("fl_issue", bus.issue, 0);
    next(); nop();
    check("fl_pend7", bus.pending[7], 1);
    check("fl_pend14", bus.pending[14], 0);
    check("fl_cycles", bus.stall_cycles, 10);
    rst = 1;
    next(); rst = 0; #1;
    check("rst2_pend", bus.pending, 0);
    check("rst2_idle", bus.idle, 1);
    check("rst2_cycles", bus.stall_cycles, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
